// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel integer clock divider.
// Imported by the channel and top-level modules.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYPASS = 2'd1,
        RUN    = 2'd2
    } ch_state_e;

    // Ratios below this pass the reference clock straight through.
    localparam int MIN_DIV_RATIO = 2;

    // Length of the high phase of a divided period (floor(r/2) cycles).
    function automatic logic [31:0] hi_len(input logic [31:0] r);
        return r >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: IDLE/BYPASS/RUN state machine, period counter and output mux.
// Ratio and enable are only taken at period boundaries so the output never glitches.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    output logic                   o_div_clk,
    output logic                   o_tick,
    output logic                   o_active
);

    ch_state_e              state_q, state_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
    logic                   div_q, div_d;
    logic                   tick_q, tick_d;

    logic at_wrap;
    logic at_boundary;
    logic ratio_ok;
    logic next_high;

    assign at_wrap  = (cnt_q == (ratio_q - RATIO_WIDTH'(1)));
    // Any non-RUN encoding (including the unused one) is treated as a boundary, so it self-recovers.
    assign at_boundary = (state_q != RUN) || at_wrap;
    assign ratio_ok    = (32'(i_div_ratio) >= 32'(MIN_DIV_RATIO));
    assign next_high   = ((32'(cnt_q) + 32'd1) < hi_len(32'(ratio_q)));

    always_comb begin
        state_d = state_q;
        ratio_d = ratio_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tick_d  = tick_q;
        if (at_boundary) begin
            if (!i_clk_en) begin
                state_d = IDLE;
                cnt_d   = '0;
                div_d   = 1'b0;
                tick_d  = 1'b0;
            end else if (!ratio_ok) begin
                state_d = BYPASS;
                cnt_d   = '0;
                div_d   = 1'b0;
                tick_d  = 1'b0;
            end else begin
                state_d = RUN;
                ratio_d = i_div_ratio;
                cnt_d   = '0;
                div_d   = 1'b1;
                tick_d  = 1'b1;
            end
        end else begin
            cnt_d  = cnt_q + RATIO_WIDTH'(1);
            div_d  = next_high;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ratio_q <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
        end
    end

    // In BYPASS the reference itself is forwarded; div_q is held low there, so leaving is clean.
    assign o_div_clk = (state_q == BYPASS) ? i_ref_clk : div_q;
    assign o_tick    = (state_q == BYPASS) | tick_q;
    assign o_active  = (state_q != IDLE);

endmodule

// File: rtl/clk_div_nch.sv
// Multi-channel integer clock divider: NUM_CH independent clk_div_ch instances
// sharing one reference clock, each with its own enable and ratio.
module clk_div_nch
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int RATIO_WIDTH = 8
) (
    input  logic                          i_ref_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_CH-1:0]             i_clk_en,
    input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]             o_div_clk,
    output logic [NUM_CH-1:0]             o_tick,
    output logic [NUM_CH-1:0]             o_active
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clk_div_ch #(
                .RATIO_WIDTH(RATIO_WIDTH)
            ) u_ch (
                .i_ref_clk  (i_ref_clk),
                .i_rst_n    (i_rst_n),
                .i_clk_en   (i_clk_en[gi]),
                .i_div_ratio(i_div_ratio[gi*RATIO_WIDTH +: RATIO_WIDTH]),
                .o_div_clk  (o_div_clk[gi]),
                .o_tick     (o_tick[gi]),
                .o_active   (o_active[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_nch.sv
// Self-checking bench for clk_div_nch: table-driven concurrent-channel runs plus
// hand-written ratio-change, disable, bypass and mid-run reset sequences.
module tb_clk_div_nch;

    localparam int NUM_CH = 4;
    localparam int RW     = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_CH-1:0]      en;
    logic [NUM_CH*RW-1:0]   ratio;
    logic [NUM_CH-1:0]      div_clk;
    logic [NUM_CH-1:0]      tick;
    logic [NUM_CH-1:0]      active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_nch #(
        .NUM_CH     (NUM_CH),
        .RATIO_WIDTH(RW)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_clk_en   (en),
        .i_div_ratio(ratio),
        .o_div_clk  (div_clk),
        .o_tick     (tick),
        .o_active   (active)
    );

    typedef struct {
        logic [NUM_CH-1:0] div;
        logic [NUM_CH-1:0] tck;
        logic [NUM_CH-1:0] act;
        logic [NUM_CH-1:0] byp;
        string             name;
    } exp_t;

    typedef struct {
        logic [NUM_CH-1:0]    en;
        logic [NUM_CH*RW-1:0] ratios;
        int                   cycles;
        logic [NUM_CH-1:0]    exp_active;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[4];

    task automatic check(input string nm, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", nm, got, want);
        end
    endtask

    // Expected is queued before the edge, popped and compared after it; the
    // second look mid-cycle proves bypass channels follow the low reference phase.
    task automatic cycle_chk(input exp_t e);
        exp_t g;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check({g.name, ".div"}, div_clk, g.div);
        check({g.name, ".tick"}, tick, g.tck);
        check({g.name, ".active"}, active, g.act);
        @(negedge clk);
        #1;
        check({g.name, ".div_low"}, div_clk, g.div & ~g.byp);
    endtask

    // Waveform of a channel n cycles after its first rising edge at ratio r.
    function automatic logic run_div(input int n, input int r);
        return (n % r) < (r / 2);
    endfunction

    function automatic logic run_tick(input int n, input int r);
        return (n % r) == 0;
    endfunction

    function automatic exp_t mk0(input logic d, input logic t, input logic a, input logic b, input string nm);
        exp_t e;
        e.div  = {3'b000, d};
        e.tck  = {3'b000, t};
        e.act  = {3'b000, a};
        e.byp  = {3'b000, b};
        e.name = nm;
        return e;
    endfunction

    task automatic do_reset(input logic [NUM_CH-1:0] en_v, input logic [NUM_CH*RW-1:0] ratio_v, input string nm);
        rst_n = 1'b0;
        en    = en_v;
        ratio = ratio_v;
        cycle_chk(mk0(1'b0, 1'b0, 1'b0, 1'b0, {nm, ".reset"}));
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   r;

        rst_n = 1'b0;
        en    = '0;
        ratio = '0;

        vecs[0] = '{en: 4'b0111, ratios: {8'd0, 8'd255, 8'd5, 8'd2}, cycles: 520, exp_active: 4'b0111};
        vecs[1] = '{en: 4'b1111, ratios: {8'd0, 8'd1, 8'd4, 8'd3},   cycles: 24,  exp_active: 4'b1111};
        vecs[2] = '{en: 4'b1010, ratios: {8'd9, 8'd8, 8'd7, 8'd6},   cycles: 40,  exp_active: 4'b1010};
        vecs[3] = '{en: 4'b0000, ratios: {8'd4, 8'd3, 8'd2, 8'd5},   cycles: 5,   exp_active: 4'b0000};

        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].en, vecs[i].ratios, $sformatf("row%0d", i));
            for (int n = 0; n < vecs[i].cycles; n++) begin
                e.div  = '0;
                e.tck  = '0;
                e.byp  = '0;
                e.act  = vecs[i].exp_active;
                e.name = $sformatf("row%0d.n%0d", i, n);
                for (int c = 0; c < NUM_CH; c++) begin
                    r = int'(vecs[i].ratios[c*RW +: RW]);
                    if (vecs[i].en[c]) begin
                        if (r < 2) begin
                            e.div[c] = 1'b1;
                            e.tck[c] = 1'b1;
                            e.byp[c] = 1'b1;
                        end else begin
                            e.div[c] = run_div(n, r);
                            e.tck[c] = run_tick(n, r);
                        end
                    end
                end
                cycle_chk(e);
            end
            $display("row %0d en=%b ratios=%h cycles=%0d done", i, vecs[i].en, vecs[i].ratios, vecs[i].cycles);
        end

        // Ratio 8 -> 3 while cnt=2: the 4/4 period completes, then 1/2 periods.
        do_reset(4'b0001, 32'd8, "ratchg");
        for (int n = 0; n < 26; n++) begin
            if (n == 3) ratio = 32'd3;
            if (n < 8) cycle_chk(mk0(run_div(n, 8), run_tick(n, 8), 1'b1, 1'b0, $sformatf("ratchg.n%0d", n)));
            else       cycle_chk(mk0(run_div(n - 8, 3), run_tick(n - 8, 3), 1'b1, 1'b0, $sformatf("ratchg.n%0d", n)));
        end
        $display("seq ratio_change 8->3 done");

        // Enable dropped in the high phase of R=4: period finishes, IDLE from the wrap edge.
        do_reset(4'b0001, 32'd4, "disable");
        for (int n = 0; n < 10; n++) begin
            if (n == 2) en = 4'b0000;
            if (n < 4) cycle_chk(mk0(run_div(n, 4), run_tick(n, 4), 1'b1, 1'b0, $sformatf("disable.n%0d", n)));
            else       cycle_chk(mk0(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("disable.n%0d", n)));
        end
        $display("seq disable_mid_high done");

        // Bypass with R=1 then R=0, then leave to R=6 at the next edge.
        do_reset(4'b0001, 32'd1, "bypass");
        for (int n = 0; n < 20; n++) begin
            if (n == 4) ratio = 32'd0;
            if (n == 8) ratio = 32'd6;
            if (n < 8) cycle_chk(mk0(1'b1, 1'b1, 1'b1, 1'b1, $sformatf("bypass.n%0d", n)));
            else       cycle_chk(mk0(run_div(n - 8, 6), run_tick(n - 8, 6), 1'b1, 1'b0, $sformatf("bypass.n%0d", n)));
        end
        $display("seq bypass_then_r6 done");

        // One-cycle reset in the middle of an R=32 high phase, then restart.
        do_reset(4'b0001, 32'd32, "rstmid");
        for (int n = 0; n < 10; n++)
            cycle_chk(mk0(run_div(n, 32), run_tick(n, 32), 1'b1, 1'b0, $sformatf("rstmid.a%0d", n)));
        rst_n = 1'b0;
        cycle_chk(mk0(1'b0, 1'b0, 1'b0, 1'b0, "rstmid.abort"));
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++)
            cycle_chk(mk0(run_div(n, 32), run_tick(n, 32), 1'b1, 1'b0, $sformatf("rstmid.b%0d", n)));
        $display("seq reset_mid_run done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_nch.md
# clk_div_nch

Multi-channel, parametrised integer clock divider. It is the successor to the single-channel divider and sits beside it in the clock-generation area. Each of NUM_CH channels divides the shared reference clock by its own runtime ratio. Ratio and enable changes are glitch-free because they are taken only at divided-period boundaries. Each channel also provides a one-cycle tick, synchronous to the reference clock, for logic that must not use the divided clock as a clock.

## Interface
- NUM_CH, 4: number of independent divider channels (≥1).
- RATIO_WIDTH, 8: width of each channel's ratio field; maximum ratio is 2^RATIO_WIDTH−1.
- i_ref_clk  input  1  reference clock; all state is clocked on its rising edge.
- i_rst_n  input  1  synchronous reset, active low; sampled on i_ref_clk rising edge.
- i_clk_en  input  NUM_CH  per-channel enable; bit c controls channel c.
- i_div_ratio  input  NUM_CH*RATIO_WIDTH  packed ratios; channel c occupies bits [c*RATIO_WIDTH +: RATIO_WIDTH].
- o_div_clk  output  NUM_CH  divided clocks.
- o_tick  output  NUM_CH  one reference-cycle pulse at the start of each divided period.
- o_active  output  NUM_CH  channel is in RUN or BYPASS.

## Operation
- Each channel holds:
  - state ∈ {IDLE, BYPASS, RUN};
  - shadow ratio ratio_q (RATIO_WIDTH bits);
  - counter cnt (RATIO_WIDTH bits);
  - registered div_q and tick_q.
- Boundary evaluation runs every cycle in IDLE and BYPASS, and in RUN only on the wrap edge (cnt == ratio_q−1). Outcome:
  - en=0 → IDLE: div_q=0, tick_q=0, cnt=0.
  - en=1 and R<2 (R=0 or 1) → BYPASS.
  - en=1 and R≥2 → RUN: ratio_q←R, cnt←0, div_q←1, tick_q←1.
- In RUN, off the wrap edge:
  - cnt←cnt+1;
  - div_q←(cnt+1 < ratio_q>>1);
  - tick_q←0;
  - i_clk_en and i_div_ratio are ignored.
- Duty cycle: high floor(R/2) cycles, low ceil(R/2) cycles.
  - R=2: 1 high / 1 low.
  - R=3: 1/2.
  - R=5: 2/3.
  - R=255: 127/128.
- Output mux per channel:
  - BYPASS: o_div_clk = i_ref_clk (combinational); o_tick = 1.
  - Otherwise: o_div_clk = div_q; o_tick = tick_q.
- o_active = (state != IDLE).
- Channels are fully independent; there is no cross-channel phase alignment.

## Timing
- Reset: on the first rising edge with i_rst_n=0, every channel goes to IDLE with cnt=0, div_q=0, tick_q=0, ratio_q=0.
  - o_div_clk=0, o_tick=0, o_active=0 from that edge until released.
  - Reset mid-period aborts the period immediately. The truncated high phase is accepted.
- Start latency: enable with R≥2 sampled at edge k → o_div_clk and o_tick high from edge k.
  - First period is exactly R cycles.
  - Rising edges of o_div_clk occur at edges k, k+R, k+2R, …
- Ratio change mid-period: the period in flight completes at the old ratio. The new R applies from the next rising edge.
- Disable mid-period: the channel finishes the current low phase. It goes IDLE at the wrap edge with o_div_clk already low, so there is no runt pulse.
- BYPASS entry:
  - From RUN, only at the wrap edge, while div_q is low; the output's next transition is the reference rising edge.
  - From IDLE, on any edge.
- BYPASS exit happens on any edge and is clean:
  - Exit to RUN coincides with the reference rising edge, so o_div_clk stays high.
  - Exit to IDLE drops o_div_clk to low; the reference is also in its high phase at that point.
- Simultaneous enable change and ratio change at a boundary are taken together; the ratio is sampled only if en=1.

## Structure
- Package clk_div_pkg holds:
  - the state enum (IDLE, BYPASS, RUN);
  - the constant MIN_DIV_RATIO = 2;
  - the half-period function hi_len(r) = r>>1.
- One sub-module, clk_div_ch: a single channel with its own state machine, counter and output mux, parametrised by RATIO_WIDTH.
- The top level slices the buses and instantiates clk_div_ch NUM_CH times in a generate loop. It contains no other logic.

## Test plan
- Ch0 R=2, en=1 after reset → o_div_clk[0] period 20 ns at 10 ns ref, 1 high / 1 low; o_tick[0] one cycle at each rising edge.
- Ch1 R=5 → 2 cycles high, 3 low, repeating; ch2 R=255 → 127 high / 128 low. Ch1 and ch2 run concurrently, unaffected by each other.
- Ch0 running R=8, ratio changed to 3 at cnt=2 → current period completes at 8 cycles (4/4). Then 1/2 periods follow; no runt pulse.
- Ch0 running R=4, en dropped mid high phase → period completes, then o_div_clk=0 and o_active=0 from the wrap edge.
- R=1 and R=0 with en=1 → o_div_clk equals i_ref_clk, o_tick=1, o_active=1. Changing to R=6 gives a 6-cycle period from the next edge.
- i_rst_n=0 for one cycle mid-RUN (R=32) → all outputs 0 from that edge. After release with en=1, the first rising edge occurs on the first edge that samples i_rst_n=1.
